// File: rtl/picomips_pkg.sv
// picomips_pkg: constants and types shared by the picoMIPS input-port slice.
//   DATA_BUS_SIZE  processor data word width (default for inport_receiver n)
//   INPORT_DEPTH   default number of input FIFO entries
//   fifo_ptr_t     FIFO pointer sized for INPORT_DEPTH
//   fifo_status_t  full/empty flags exported by inport_fifo
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

package picomips_pkg;

    localparam int DATA_BUS_SIZE = `DATA_BUS_SIZE;
    localparam int INPORT_DEPTH  = 4;

    typedef logic [$clog2(INPORT_DEPTH)-1:0] fifo_ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_status_t;

endpackage

// File: rtl/inport_fifo.sv
// inport_fifo: depth x n circular buffer with occupancy counter.
//   clk, reset  clock, async active-high reset (pointers/count only)
//   push, wdata write request; ignored while full
//   pop         read request; ignored while empty
//   rdata       current head word, combinational from mem[rp]
//   status      full / empty, derived from registered count only
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

module inport_fifo
    import picomips_pkg::*;
#(
    parameter int n     = `DATA_BUS_SIZE,
    parameter int depth = INPORT_DEPTH   // power of two, >= 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [n-1:0] wdata,
    input  logic         pop,
    output logic [n-1:0] rdata,
    output fifo_status_t status
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [n-1:0]  mem [depth];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign status.full  = (count == CW'(depth));
    assign status.empty = (count == '0);

    // A full FIFO refuses pushes even when a pop lands on the same edge,
    // so accepting a word never depends on the consumer side.
    assign do_push = push && !status.full;
    assign do_pop  = pop  && !status.empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; empty entries are never
    // observed because the output mux selects 'last' whenever count is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];

endmodule

// File: rtl/inport_receiver.sv
// inport_receiver: picoMIPS input-port front end (register %1 source).
//   clk, reset          clock, async active-high reset
//   in_data, in_valid   producer word + valid
//   in_ready            space available (state-only, no path from pop)
//   pop                 control pulse: instruction reading %1 committed
//   inport              head word, or last consumed word when empty
//   avail               inport holds an unconsumed word
//   overrun, clr_flags  sticky pop-while-empty flag and its clear
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

module inport_receiver
    import picomips_pkg::*;
#(
    parameter int n     = `DATA_BUS_SIZE,
    parameter int depth = INPORT_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         pop,
    output logic [n-1:0] inport,
    output logic         avail,
    output logic         overrun,
    input  logic         clr_flags
);

    fifo_status_t st;
    logic [n-1:0] head;
    logic [n-1:0] last;
    logic         pop_ok;

    inport_fifo #(.n(n), .depth(depth)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (in_valid && in_ready),
        .wdata  (in_data),
        .pop    (pop_ok),
        .rdata  (head),
        .status (st)
    );

    assign in_ready = !st.full;
    assign avail    = !st.empty;
    assign pop_ok   = pop && avail;

    // Holding the consumed word keeps repeated reads of %1 stable once
    // the buffer drains.
    assign inport = avail ? head : last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last    <= '0;
            overrun <= 1'b0;
        end else begin
            if (pop_ok) last <= head;
            // Setting wins over clearing so a same-cycle event is not lost.
            if (pop && !avail)  overrun <= 1'b1;
            else if (clr_flags) overrun <= 1'b0;
        end
    end

endmodule
